// File: rtl/gat_feat_rd_pkg.sv
// Shared types and constants for the GAT feature readback path.
// Honours GAT_FEAT_RD_PACK_EN (four 8-bit features per stream beat).
package gat_feat_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int BYTE_ADDR_SHIFT = 2;
  localparam int PACK_RATIO      = 4;
  localparam int DATA_W          = 32;

  function automatic int beats_per_frame(input int depth);
`ifdef GAT_FEAT_RD_PACK_EN
    return depth / PACK_RATIO;
`else
    return depth;
`endif
  endfunction

endpackage

// File: rtl/gat_sync_fifo.sv
// Small synchronous FIFO with occupancy count; simultaneous push and pop
// are accepted even when full.
module gat_sync_fifo
  import gat_feat_rd_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gat_feat_stream_reader.sv
// Walks the GAT new-feature BRAM after gat_ready and streams it as one framed AXI-Stream burst.
// Build option GAT_FEAT_RD_PACK_EN packs four 8-bit features per beat.
module gat_feat_stream_reader
  import gat_feat_rd_pkg::*;
#(
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int RD_LATENCY         = 1,
  parameter int FIFO_DEPTH         = RD_LATENCY + 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            gat_ready,
  output logic                            busy,
  output logic                            done,
  output logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb,
  input  logic [31:0]                     feat_bram_dout,
  output logic [31:0]                     m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
);

  localparam int BEATS  = beats_per_frame(NEW_FEATURE_DEPTH);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRED_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

  rd_state_e                     r_state;
  rd_state_e                     w_state_nxt;
  logic [NEW_FEATURE_ADDR_W-1:0] r_rd_idx;
  logic [RD_LATENCY-1:0]         r_vld;
  logic [BEAT_W-1:0]             r_out_idx;
  logic                          r_busy;
  logic                          r_done;

  logic [CRED_W-1:0]             w_in_flight;
  logic                          w_credit_ok;
  logic                          w_accept;
  logic                          w_issue;
  logic                          w_last_issue;
  logic                          w_tap;
  logic                          w_push;
  logic [31:0]                   w_push_data;
  logic [31:0]                   w_fifo_data;
  logic [FCNT_W-1:0]             w_fifo_cnt;
  logic                          w_fifo_empty;
  logic                          w_tvalid;
  logic                          w_hs;
  logic                          w_last_beat;
  logic                          w_final_hs;

  // reads still travelling through the BRAM pipeline
  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_in_flight = w_in_flight + CRED_W'(r_vld[i]);
    end
  end

  // Credit covers in-flight reads as well as buffered beats, so a push always finds room.
  assign w_credit_ok  = (w_in_flight + CRED_W'(w_fifo_cnt)) < CRED_W'(FIFO_DEPTH);
  assign w_accept     = (r_state == IDLE) && start && gat_ready;
  assign w_issue      = (r_state == READ) && w_credit_ok;
  assign w_last_issue = w_issue && (r_rd_idx == NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1));
  assign w_tap        = r_vld[RD_LATENCY-1];
  assign w_tvalid     = !w_fifo_empty;
  assign w_hs         = w_tvalid && m_axis_tready;
  assign w_last_beat  = (r_out_idx == BEAT_W'(BEATS - 1));
  assign w_final_hs   = w_hs && w_last_beat;

`ifdef GAT_FEAT_RD_PACK_EN
  logic [1:0]  r_pack_cnt;
  logic [23:0] r_pack;

  if (NEW_FEATURE_DEPTH % PACK_RATIO != 0) begin : g_depth_chk
    $error("NEW_FEATURE_DEPTH must be a multiple of PACK_RATIO");
  end

  assign w_push      = w_tap && (r_pack_cnt == 2'd3);
  assign w_push_data = {feat_bram_dout[7:0], r_pack};

  // gather the first three bytes of each packed beat, little-endian
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pack_cnt <= 2'd0;
      r_pack     <= 24'd0;
    end else if (w_tap) begin
      r_pack_cnt <= r_pack_cnt + 2'd1;
      case (r_pack_cnt)
        2'd0:    r_pack[7:0]   <= feat_bram_dout[7:0];
        2'd1:    r_pack[15:8]  <= feat_bram_dout[7:0];
        2'd2:    r_pack[23:16] <= feat_bram_dout[7:0];
        default: r_pack        <= r_pack;
      endcase
    end
  end
`else
  assign w_push      = w_tap;
  assign w_push_data = feat_bram_dout;
`endif

  gat_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32),
    .CNT_W (FCNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_hs),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_cnt),
    .o_empty (w_fifo_empty)
  );

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = READ;
        else          w_state_nxt = IDLE;
      end
      READ: begin
        if (w_last_issue) w_state_nxt = DRAIN;
        else              w_state_nxt = READ;
      end
      DRAIN: begin
        if (w_final_hs) w_state_nxt = IDLE;
        else            w_state_nxt = DRAIN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // state, read index, latency pipe, beat index and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rd_idx  <= '0;
      r_vld     <= '0;
      r_out_idx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_rd_idx <= w_last_issue ? '0 : r_rd_idx + NEW_FEATURE_ADDR_W'(1);
      end
      r_vld[0] <= w_issue;
      for (int i = 1; i < RD_LATENCY; i++) r_vld[i] <= r_vld[i-1];
      if (w_hs) begin
        r_out_idx <= w_last_beat ? '0 : r_out_idx + BEAT_W'(1);
      end
      if (w_accept)        r_busy <= 1'b1;
      else if (w_final_hs) r_busy <= 1'b0;
      r_done <= w_final_hs;
    end
  end

  assign feat_bram_addrb = {r_rd_idx, {BYTE_ADDR_SHIFT{1'b0}}};
  assign m_axis_tvalid   = w_tvalid;
  assign m_axis_tdata    = w_tvalid ? w_fifo_data : 32'd0;
  assign m_axis_tlast    = w_tvalid && w_last_beat;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule
